// File: rtl/fpadd_input_ctrl_if.sv
// Button/switch inputs and adder-launch/display outputs of the FP adder front end.
interface fpadd_input_ctrl_if;
  logic        btn_start;
  logic        btn_show;
  logic [15:0] sw;
  logic [7:0]  a_out;
  logic [7:0]  b_out;
  logic        start_pulse;
  logic        show_sum;
  logic        busy;
  logic        done;

  modport slave (
    input  btn_start, btn_show, sw,
    output a_out, b_out, start_pulse, show_sum, busy, done
  );

  modport master (
    output btn_start, btn_show, sw,
    input  a_out, b_out, start_pulse, show_sum, busy, done
  );
endinterface

// File: rtl/fpadd_input_ctrl.sv
// FP adder front end: button sync/debounce, operand latch, launch strobe and latency tracking.
// Optional FPADD_AUTO_SHOW_EN: show_sum auto-set on DONE entry and auto-cleared on LAUNCH entry.
module fpadd_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ADD_LATENCY     = 4
) (
  input  logic                clk,
  input  logic                clr,
  fpadd_input_ctrl_if.slave   io
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int LAT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

  generate
    if (ADD_LATENCY < 1 || DEBOUNCE_CYCLES < 2) begin : g_param_chk
      $error("fpadd_input_ctrl: need ADD_LATENCY >= 1 and DEBOUNCE_CYCLES >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  // Index 0 = start button, index 1 = show button.
  logic [1:0]       sync1, sync2;
  logic [1:0]       db_lvl, db_lvl_q;
  logic [CNT_W-1:0] db_cnt [2];
  logic [1:0]       rise;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_nxt;
  logic             latch_ops;
  logic             show_nxt;

  logic [7:0]       a_q, b_q;
  logic             pulse_q, busy_q, done_q, show_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {io.btn_show, io.btn_start};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      db_lvl   <= '0;
      db_lvl_q <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      db_lvl_q <= db_lvl;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_lvl[i] <= ~db_lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = db_lvl & ~db_lvl_q;

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    latch_ops = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (rise[0]) begin
          state_nxt = S_LAUNCH;
          latch_ops = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_nxt = S_WAIT;
        lat_nxt   = LAT_W'(ADD_LATENCY - 1);
      end
      S_WAIT: begin
        // Leave on the cycle the count reaches 0, so done trails start_pulse by
        // ADD_LATENCY; a zero load (ADD_LATENCY=1) still spends one cycle here.
        if (lat_cnt <= LAT_W'(1)) begin
          state_nxt = S_DONE;
          lat_nxt   = '0;
        end else begin
          lat_nxt = lat_cnt - LAT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    show_nxt = show_q ^ rise[1];
`ifdef FPADD_AUTO_SHOW_EN
    if (latch_ops)
      show_nxt = 1'b0;
    else if (state == S_WAIT && state_nxt == S_DONE)
      show_nxt = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      show_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      if (latch_ops) begin
        a_q <= io.sw[15:8];
        b_q <= io.sw[7:0];
      end
      // Outputs registered from the next state so they change cleanly with state.
      pulse_q <= (state_nxt == S_LAUNCH);
      busy_q  <= (state_nxt == S_LAUNCH) || (state_nxt == S_WAIT);
      done_q  <= (state_nxt == S_DONE);
      show_q  <= show_nxt;
    end
  end

  assign io.a_out       = a_q;
  assign io.b_out       = b_q;
  assign io.start_pulse = pulse_q;
  assign io.busy        = busy_q;
  assign io.done        = done_q;
  assign io.show_sum    = show_q;

endmodule

// File: tb/tb_fpadd_input_ctrl.sv
// Self-checking bench for fpadd_input_ctrl: directed scenarios plus random buttons/switches vs a timing model.
module tb_fpadd_input_ctrl;
  localparam int D = 4;
  localparam int L = 3;
  localparam int HMAX = 20000;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  fpadd_input_ctrl_if bus ();

  fpadd_input_ctrl #(.DEBOUNCE_CYCLES(D), .ADD_LATENCY(L)) dut (
    .clk (clk),
    .clr (clr),
    .io  (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: button sample history, debounced levels, and the cycle of the last accepted launch.
  bit       hist [2][HMAX];
  int       k;
  bit [1:0] m_db, m_db_prev;
  bit       launched;
  int       launch_k;
  bit [7:0] ea, eb;
  bit       es;
  int       pulse_seen, busy_seen;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit hget(input int b, input int i);
    if (i < 1 || i >= HMAX) return 1'b0;
    return hist[b][i];
  endfunction

  task automatic model_reset();
    k = 0; m_db = '0; m_db_prev = '0;
    launched = 0; launch_k = 0; ea = '0; eb = '0; es = 0;
  endtask

  // Debounced level flips once the last D synchronized samples all disagree with it.
  function automatic bit flips(input int b);
    for (int j = 0; j < D; j++)
      if (hget(b, k - j - 2) == m_db[b]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit [1:0] rs;
    bit [1:0] nd;
    k++;
    rs = m_db & ~m_db_prev;
    for (int b = 0; b < 2; b++) nd[b] = flips(b) ? ~m_db[b] : m_db[b];
    if (k < HMAX) begin
      hist[0][k] = bus.btn_start;
      hist[1][k] = bus.btn_show;
    end
    m_db_prev = m_db;
    m_db = nd;
    if (rs[0] && (!launched || (k - 1 - launch_k) >= L)) begin
      launched = 1; launch_k = k;
      ea = bus.sw[15:8]; eb = bus.sw[7:0];
    end
    if (rs[1]) es = ~es;
`ifdef FPADD_AUTO_SHOW_EN
    if (launched && launch_k == k) es = 0;
    else if (launched && (k - launch_k) == L) es = 1;
`endif
  endtask

  task automatic check_all();
    int ph;
    ph = launched ? (k - launch_k) : 1000000;
    chk("a_out", bus.a_out, ea);
    chk("b_out", bus.b_out, eb);
    chk("start_pulse", {7'b0, bus.start_pulse}, {7'b0, ph == 0});
    chk("busy", {7'b0, bus.busy}, {7'b0, ph < L});
    chk("done", {7'b0, bus.done}, {7'b0, launched && ph >= L});
    chk("show_sum", {7'b0, bus.show_sum}, {7'b0, es});
  endtask

  task automatic tick();
    @(posedge clk);
    if (clr) model_edge();
    #1;
    check_all();
    pulse_seen += int'(bus.start_pulse === 1'b1);
    busy_seen  += int'(bus.busy === 1'b1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_start(input int hi, input int lo);
    bus.btn_start = 1'b1; run(hi);
    bus.btn_start = 1'b0; run(lo);
  endtask

  task automatic press_show(input int hi, input int lo);
    bus.btn_show = 1'b1; run(hi);
    bus.btn_show = 1'b0; run(lo);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int hold_s, hold_w, guard;
    bit exp_sh;

    // Reset with buttons held and all switches high.
    bus.btn_start = 1'b1; bus.btn_show = 1'b1; bus.sw = 16'hFFFF;
    clr = 1'b0;
    model_reset();
    #1 check_all();
    run(4);
    bus.btn_start = 1'b0; bus.btn_show = 1'b0;
    #2 clr = 1'b1;
    pulse_seen = 0;
    run(10);
    chk("no_pulse_after_reset", pulse_seen[7:0], 8'd0);

    // Basic launch.
    bus.sw = 16'h3A45;
    pulse_seen = 0; busy_seen = 0;
    press_start(20, 20);
    chk("launch_a", bus.a_out, 8'h3A);
    chk("launch_b", bus.b_out, 8'h45);
    chk("pulse_count", pulse_seen[7:0], 8'd1);
    chk("busy_cycles", busy_seen[7:0], 8'd3);
    chk("done_hold", {7'b0, bus.done}, 8'd1);

    // Bounce rejection, with switches changing meanwhile.
    bus.sw = 16'hBEEF;
    pulse_seen = 0;
    for (int i = 0; i < 15; i++) begin
      bus.btn_start = ~bus.btn_start;
      run(2);
    end
    bus.btn_start = 1'b0;
    run(12);
    chk("bounce_pulses", pulse_seen[7:0], 8'd0);
    chk("bounce_a", bus.a_out, 8'h3A);
    chk("bounce_b", bus.b_out, 8'h45);

    // Quick second press after a launch, then a relaunch from DONE.
    bus.sw = 16'h5566;
    press_start(8, 3);
    press_start(10, 12);
    bus.sw = 16'h1122;
    press_start(10, 12);
    chk("relaunch_a", bus.a_out, 8'h11);
    chk("relaunch_b", bus.b_out, 8'h22);
    chk("relaunch_done", {7'b0, bus.done}, 8'd1);

    // Show toggles; expectations follow the model's level before the presses.
    exp_sh = es;
    for (int i = 0; i < 3; i++) begin
      press_show(8, 8);
      exp_sh = ~exp_sh;
      chk("show_toggle", {7'b0, bus.show_sum}, {7'b0, exp_sh});
    end

    // Simultaneous start and show presses.
    bus.sw = 16'h7788;
    bus.btn_start = 1'b1; bus.btn_show = 1'b1; run(10);
    bus.btn_start = 1'b0; bus.btn_show = 1'b0; run(12);
    chk("simul_a", bus.a_out, 8'h77);

    // Asynchronous reset while waiting on the adder.
    bus.sw = 16'h9ABC;
    bus.btn_start = 1'b1;
    guard = 0;
    while (!(launched && (k - launch_k) == 1) && guard < 40) begin
      tick();
      guard++;
    end
    chk("reached_wait", {7'b0, launched && (k - launch_k) == 1}, 8'd1);
    bus.btn_start = 1'b0;
    #2 clr = 1'b0;
    model_reset();
    #1 check_all();
    chk("async_busy_clear", {7'b0, bus.busy}, 8'd0);
    run(2);
    #2 clr = 1'b1;
    pulse_seen = 0;
    run(20);
    chk("post_reset_pulse", pulse_seen[7:0], 8'd0);
    chk("post_reset_done", {7'b0, bus.done}, 8'd0);

    // Random buttons and switches against the model.
    hold_s = 1; hold_w = 1;
    for (int i = 0; i < 1500; i++) begin
      bus.sw = 16'($urandom);
      if (--hold_s == 0) begin
        bus.btn_start = ~bus.btn_start;
        hold_s = int'($urandom_range(1, 12));
      end
      if (--hold_w == 0) begin
        bus.btn_show = ~bus.btn_show;
        hold_w = int'($urandom_range(1, 12));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
